// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: two-entry skid buffer toward write-back,
// committed PSW register and branch-condition evaluation.
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_cf,
    input  logic              in_zf,
    input  logic              in_sf,
    input  logic              in_of,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    input  logic              in_setf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic [3:0]        flags,
    input  logic [2:0]        cond,
    output logic              cond_true
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_result;
    logic [RD_W-1:0]   main_rd;
    logic              main_wen;
    logic [DATA_W-1:0] skid_result;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_wen;
    logic              accept;
    logic              pop;

    // Ready comes only from the state register, never from out_ready.
    assign in_ready   = (state != FULL);
    assign out_valid  = (state != EMPTY);
    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_wen    = main_wen;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_result <= '0;
            main_rd     <= '0;
            main_wen    <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_wen    <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        main_result <= in_result;
                        main_rd     <= in_rd;
                        main_wen    <= in_wen;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_result <= in_result;
                        main_rd     <= in_rd;
                        main_wen    <= in_wen;
                    end else if (accept) begin
                        state       <= FULL;
                        skid_result <= in_result;
                        skid_rd     <= in_rd;
                        skid_wen    <= in_wen;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state       <= ONE;
                        main_result <= skid_result;
                        main_rd     <= skid_rd;
                        main_wen    <= skid_wen;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // PSW commits at acceptance, independent of write-back stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (accept && in_setf) begin
            flags <= {in_cf, in_zf, in_sf, in_of};
        end
    end

    logic cf;
    logic zf;
    logic sf;
    logic of;

    assign {cf, zf, sf, of} = flags;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'd0: cond_true = zf;
            3'd1: cond_true = ~zf;
            3'd2: cond_true = sf ^ of;
            3'd3: cond_true = ~(sf ^ of);
            3'd4: cond_true = cf;
            3'd5: cond_true = ~cf;
            3'd6: cond_true = sf;
            3'd7: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, skid buffer, PSW,
// condition decode, flush and asynchronous reset.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_cf;
    logic        in_zf;
    logic        in_sf;
    logic        in_of;
    logic [2:0]  in_rd;
    logic        in_wen;
    logic        in_setf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wen;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        cond_true;

    int checks;
    int failures;

    alu_result_stage #(.DATA_W(16), .RD_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_cf(in_cf),
        .in_zf(in_zf),
        .in_sf(in_sf),
        .in_of(in_of),
        .in_rd(in_rd),
        .in_wen(in_wen),
        .in_setf(in_setf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_rd(out_rd),
        .out_wen(out_wen),
        .flags(flags),
        .cond(cond),
        .cond_true(cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags_in(input logic [3:0] f);
        {in_cf, in_zf, in_sf, in_of} = f;
    endtask

    task automatic chk_conds(input string tag, input logic [7:0] exp);
        for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            #1;
            chk($sformatf("%s_cond%0d", tag, c), 32'(cond_true), 32'(exp[c]));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        in_setf   = 1'b0;
        set_flags_in(4'b0000);
        out_ready = 1'b0;
        cond      = 3'd0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single result
        in_valid  = 1'b1;
        in_result = 16'h1234;
        in_rd     = 3'd3;
        in_wen    = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", 32'(out_result), 32'h1234);
        chk("t1_out_rd", 32'(out_rd), 32'd3);
        chk("t1_out_wen", 32'(out_wen), 32'd1);
        in_valid = 1'b0;
        step();
        chk("t1_empty", 32'(out_valid), 32'd0);

        // Back-pressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 16'h0001;
        in_rd     = 3'd1;
        step();
        chk("t2_one_ready", 32'(in_ready), 32'd1);
        in_result = 16'h0002;
        in_rd     = 3'd2;
        step();
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        chk("t2_full_head", 32'(out_result), 32'h0001);
        in_result = 16'h0003;
        in_rd     = 3'd4;
        step();
        chk("t2_held_ready", 32'(in_ready), 32'd0);
        chk("t2_held_head", 32'(out_result), 32'h0001);
        chk("t2_held_rd", 32'(out_rd), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t2_second_valid", 32'(out_valid), 32'd1);
        chk("t2_second", 32'(out_result), 32'h0002);
        chk("t2_second_rd", 32'(out_rd), 32'd2);
        chk("t2_second_ready", 32'(in_ready), 32'd1);
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // PSW commit and condition decode
        in_valid = 1'b1;
        in_setf  = 1'b1;
        set_flags_in(4'b1010);
        step();
        chk("t3_flags_a", 32'(flags), 32'hA);
        chk_conds("t3a", 8'b1101_0110);
        in_setf = 1'b0;
        set_flags_in(4'b0100);
        step();
        chk("t3_flags_hold", 32'(flags), 32'hA);
        in_setf = 1'b1;
        set_flags_in(4'b0101);
        step();
        chk("t3_flags_b", 32'(flags), 32'h5);
        chk_conds("t3b", 8'b1010_0101);
        in_valid = 1'b0;
        in_setf  = 1'b0;
        step();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Flush while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        chk("t4_full", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_setf = 1'b1;
        set_flags_in(4'b1111);
        step();
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_flags", 32'(flags), 32'h5);
        flush    = 1'b0;
        in_valid = 1'b0;
        in_setf  = 1'b0;
        step();
        chk("t4_still_empty", 32'(out_valid), 32'd0);

        // Async reset mid-FULL
        in_valid = 1'b1;
        in_setf  = 1'b1;
        set_flags_in(4'b1100);
        step();
        step();
        chk("t5_full", 32'(in_ready), 32'd0);
        chk("t5_flags", 32'(flags), 32'hC);
        in_valid = 1'b0;
        in_setf  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_flags_clr", 32'(flags), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_out_result", 32'(out_result), 32'd0);
        #2;
        rst = 1'b0;

        // Streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rd     = 3'd5;
        for (int i = 0; i < 8; i++) begin
            in_result = 16'(i);
            step();
            chk($sformatf("t6_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t6_data%0d", i), 32'(out_result), 32'(i));
            chk($sformatf("t6_ready%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t6_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
